// File: rtl/pb_debounce_bank.sv
// Multi-channel push-button conditioner: shared sample-tick divider, per-channel
// window debounce with hysteresis, press/release strobes and a long-press strobe.
module pb_debounce_bank #(
    parameter int CH         = 4,
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 1,
    parameter int HOLD_TICKS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] pb_in,
    output logic [CH-1:0] pb_level,
    output logic [CH-1:0] pb_press,
    output logic [CH-1:0] pb_release,
    output logic [CH-1:0] pb_long
);

    localparam int              CW       = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0]   HOLD_MAX = CW'(HOLD_TICKS);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic tick;

    generate
        if (SAMPLE_DIV == 1) begin : g_no_div
            assign tick = 1'b1;
        end else begin : g_div
            localparam int            DW       = $clog2(SAMPLE_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
            localparam logic [DW-1:0] DIV_ONE  = DW'(1);

            logic [DW-1:0] div_cnt;

            assign tick = (div_cnt == DIV_LAST);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    div_cnt <= '0;
                end else if (tick) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
            end
        end
    endgenerate

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [DEPTH-1:0] win;
        logic [CW-1:0]    hold_cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             long_q;
        logic             level_nxt;

        // A mixed window keeps the previous level, which is what suppresses chatter.
        always_comb begin
            level_nxt = level_q;
            if (&win) begin
                level_nxt = 1'b1;
            end else if (~|win) begin
                level_nxt = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                win       <= '0;
                hold_cnt  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                if (tick) begin
                    win <= {win[DEPTH-2:0], pb_in[i]};
                end
                level_q   <= level_nxt;
                press_q   <= level_nxt & ~level_q;
                release_q <= ~level_nxt & level_q;
                long_q    <= 1'b0;
                // Clearing on the falling level wins over a same-edge increment.
                if (!level_nxt) begin
                    hold_cnt <= '0;
                end else if (tick && level_q && (hold_cnt < HOLD_MAX)) begin
                    hold_cnt <= hold_cnt + CNT_ONE;
                    long_q   <= ((hold_cnt + CNT_ONE) == HOLD_MAX);
                end
            end
        end

        assign pb_level[i]   = level_q;
        assign pb_press[i]   = press_q;
        assign pb_release[i] = release_q;
        assign pb_long[i]    = long_q;
    end

endmodule

// File: tb/tb_pb_debounce_bank.sv
// Directed bench for pb_debounce_bank: one instance with SAMPLE_DIV=1 and one with SAMPLE_DIV=3.
module tb_pb_debounce_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] pb_in;
    logic [3:0] pb_level;
    logic [3:0] pb_press;
    logic [3:0] pb_release;
    logic [3:0] pb_long;
    logic [3:0] pb_in3;
    logic [3:0] pb_level3;
    logic [3:0] pb_press3;
    logic [3:0] pb_release3;
    logic [3:0] pb_long3;

    int passed;
    int total;
    int ph3;

    pb_debounce_bank #(.CH(4), .DEPTH(4), .SAMPLE_DIV(1), .HOLD_TICKS(8)) dut (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
        .pb_level(pb_level), .pb_press(pb_press),
        .pb_release(pb_release), .pb_long(pb_long)
    );

    pb_debounce_bank #(.CH(4), .DEPTH(4), .SAMPLE_DIV(3), .HOLD_TICKS(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in3),
        .pb_level(pb_level3), .pb_press(pb_press3),
        .pb_release(pb_release3), .pb_long(pb_long3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phase of the divide-by-3 sampler: the next edge is a tick edge when ph3 == 2.
    always @(posedge clk) begin
        if (!rst_n) ph3 <= 0;
        else        ph3 <= (ph3 == 2) ? 0 : ph3 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        pb_in  = 4'b0000;
        pb_in3 = 4'b0000;
        step();
        step();
        total++; if (pb_level   !== 4'b0000) $display("FAIL reset_level: got %b want 0000", pb_level);   else passed++;
        total++; if (pb_press   !== 4'b0000) $display("FAIL reset_press: got %b want 0000", pb_press);   else passed++;
        total++; if (pb_release !== 4'b0000) $display("FAIL reset_release: got %b want 0000", pb_release); else passed++;
        total++; if (pb_long    !== 4'b0000) $display("FAIL reset_long: got %b want 0000", pb_long);     else passed++;
        total++; if ({pb_level3, pb_press3, pb_release3, pb_long3} !== 16'h0000)
            $display("FAIL reset_div3: got %h want 0000", {pb_level3, pb_press3, pb_release3, pb_long3});
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        logic exp_long;
        pb_in = 4'b0001;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 4) begin
                total++; if (pb_level[0] !== 1'b0) $display("FAIL press_early_level: got %b want 0", pb_level[0]); else passed++;
            end
            if (e == 5) begin
                total++; if (pb_level[0] !== 1'b1) $display("FAIL press_level: got %b want 1", pb_level[0]); else passed++;
                total++; if (pb_press[0] !== 1'b1) $display("FAIL press_strobe: got %b want 1", pb_press[0]); else passed++;
            end
            if (e == 6) begin
                total++; if (pb_press[0] !== 1'b0) $display("FAIL press_width: got %b want 0", pb_press[0]); else passed++;
            end
            if (e >= 6) begin
                exp_long = (e == 13);
                total++;
                if (pb_long[0] !== exp_long) $display("FAIL press_long_e%0d: got %b want %b", e, pb_long[0], exp_long);
                else passed++;
            end
        end
    endtask

    task automatic test_bounce();
        bit   bpat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic lvl_seen;
        logic strb_seen;
        lvl_seen  = 1'b0;
        strb_seen = 1'b0;
        for (int e = 0; e < 14; e++) begin
            pb_in[1] = (e < 8) ? bpat[e] : 1'b0;
            step();
            lvl_seen  = lvl_seen | pb_level[1];
            strb_seen = strb_seen | pb_press[1] | pb_release[1] | pb_long[1];
        end
        total++; if (lvl_seen  !== 1'b0) $display("FAIL bounce_level: got %b want 0", lvl_seen);  else passed++;
        total++; if (strb_seen !== 1'b0) $display("FAIL bounce_strobes: got %b want 0", strb_seen); else passed++;
        total++; if (pb_level[0] !== 1'b1) $display("FAIL bounce_ch0_held: got %b want 1", pb_level[0]); else passed++;
    endtask

    task automatic test_release_hysteresis();
        logic bad;
        logic long_seen;
        // single-cycle low on a debounced-high channel
        pb_in[0] = 1'b0;
        step();
        pb_in[0] = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            step();
            bad = bad | ~pb_level[0] | pb_release[0];
        end
        total++; if (bad !== 1'b0) $display("FAIL hyst_glitch: got %b want 0", bad); else passed++;

        pb_in[0] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 4) begin
                total++; if (pb_level[0] !== 1'b1) $display("FAIL rel_early_level: got %b want 1", pb_level[0]); else passed++;
            end
            if (e == 5) begin
                total++; if (pb_level[0] !== 1'b0) $display("FAIL rel_level: got %b want 0", pb_level[0]); else passed++;
                total++; if (pb_release[0] !== 1'b1) $display("FAIL rel_strobe: got %b want 1", pb_release[0]); else passed++;
            end
            if (e == 6) begin
                total++; if (pb_release[0] !== 1'b0) $display("FAIL rel_width: got %b want 0", pb_release[0]); else passed++;
            end
        end

        // re-press: a cleared hold count must reach 8 again after exactly 8 ticks
        pb_in[0] = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e == 12) begin
                total++; if (pb_long[0] !== 1'b0) $display("FAIL repress_long_e12: got %b want 0", pb_long[0]); else passed++;
            end
            if (e == 13) begin
                total++; if (pb_long[0] !== 1'b1) $display("FAIL repress_long_e13: got %b want 1", pb_long[0]); else passed++;
            end
        end

        pb_in[0] = 1'b0;
        repeat (6) step();

        // release so the level falls on the 5th tick of the hold
        long_seen = 1'b0;
        pb_in[0] = 1'b1;
        repeat (5) begin step(); long_seen = long_seen | pb_long[0]; end
        pb_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            long_seen = long_seen | pb_long[0];
            if (e == 5) begin
                total++; if (pb_release[0] !== 1'b1) $display("FAIL tick5_release: got %b want 1", pb_release[0]); else passed++;
            end
        end
        total++; if (long_seen !== 1'b0) $display("FAIL tick5_no_long: got %b want 0", long_seen); else passed++;

        // level falls on the edge where the count would step 7 -> 8
        long_seen = 1'b0;
        pb_in[0] = 1'b1;
        repeat (8) begin step(); long_seen = long_seen | pb_long[0]; end
        pb_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            long_seen = long_seen | pb_long[0];
            if (e == 5) begin
                total++; if (pb_release[0] !== 1'b1) $display("FAIL clr_prio_release: got %b want 1", pb_release[0]); else passed++;
            end
        end
        total++; if (long_seen !== 1'b0) $display("FAIL clr_prio_no_long: got %b want 0", long_seen); else passed++;
    endtask

    task automatic test_sample_div3();
        for (int k = 0; k < 4; k++) begin
            if (ph3 != 0) step();
        end
        for (int e = 1; e <= 14; e++) begin
            pb_in3[2] = (e == 4 || e == 5) ? 1'b0 : 1'b1;
            step();
            if (e == 12) begin
                total++; if (pb_level3[2] !== 1'b0) $display("FAIL div3_early_level: got %b want 0", pb_level3[2]); else passed++;
            end
            if (e == 13) begin
                total++; if (pb_level3[2] !== 1'b1) $display("FAIL div3_level: got %b want 1", pb_level3[2]); else passed++;
                total++; if (pb_press3 !== 4'b0100) $display("FAIL div3_press: got %b want 0100", pb_press3); else passed++;
            end
            if (e == 14) begin
                total++; if (pb_press3 !== 4'b0000) $display("FAIL div3_press_width: got %b want 0000", pb_press3); else passed++;
            end
        end
        pb_in3 = 4'b0000;
    endtask

    task automatic test_reset_mid_press();
        pb_in = 4'b1000;
        repeat (10) step();
        total++; if (pb_level[3] !== 1'b1) $display("FAIL midrst_pre_level: got %b want 1", pb_level[3]); else passed++;
        rst_n = 1'b0;
        step();
        total++; if ({pb_level, pb_press, pb_release, pb_long} !== 16'h0000)
            $display("FAIL midrst_outputs: got %h want 0000", {pb_level, pb_press, pb_release, pb_long});
        else passed++;
        rst_n = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e == 4) begin
                total++; if (pb_press[3] !== 1'b0) $display("FAIL midrst_early_press: got %b want 0", pb_press[3]); else passed++;
            end
            if (e == 5) begin
                total++; if (pb_press[3] !== 1'b1) $display("FAIL midrst_press: got %b want 1", pb_press[3]); else passed++;
            end
            if (e == 12) begin
                total++; if (pb_long[3] !== 1'b0) $display("FAIL midrst_long_e12: got %b want 0", pb_long[3]); else passed++;
            end
            if (e == 13) begin
                total++; if (pb_long[3] !== 1'b1) $display("FAIL midrst_long_e13: got %b want 1", pb_long[3]); else passed++;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] quiet;
        pb_in = 4'b0010;
        repeat (6) step();
        pb_in = 4'b0001;
        quiet = 8'h00;
        for (int e = 1; e <= 6; e++) begin
            step();
            quiet = quiet | {pb_level[3:2], pb_press[3:2], pb_release[3:2], pb_long[3:2]};
            if (e == 5) begin
                total++; if (pb_press   !== 4'b0001) $display("FAIL simul_press: got %b want 0001", pb_press);     else passed++;
                total++; if (pb_release !== 4'b0010) $display("FAIL simul_release: got %b want 0010", pb_release); else passed++;
                total++; if (pb_level   !== 4'b0001) $display("FAIL simul_level: got %b want 0001", pb_level);     else passed++;
            end
            if (e == 6) begin
                total++; if ({pb_press, pb_release} !== 8'h00) $display("FAIL simul_width: got %h want 00", {pb_press, pb_release}); else passed++;
            end
        end
        total++; if (quiet !== 8'h00) $display("FAIL simul_ch23_quiet: got %h want 00", quiet); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        pb_in  = 4'b0000;
        pb_in3 = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_hysteresis();
        test_sample_div3();
        test_reset_mid_press();
        test_simultaneous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pb_debounce_bank.md
# pb_debounce_bank

Multi-channel push-button conditioner that replaces per-button single-channel debouncers in the board-level input path. It provides a configurable sample rate and window depth, symmetric press/release qualification (hysteresis), one-cycle press/release strobes, and a per-channel long-press strobe. It sits between the raw FPGA button pins, which are already synchronised upstream, and the game/control FSMs. Those FSMs consume the strobes directly instead of building their own one-pulse logic.

## Interface
- CH, 4: number of independent button channels (≥1).
- DEPTH, 4: consecutive equal samples needed to change the debounced level (≥2).
- SAMPLE_DIV, 1: clocks per sample tick (≥1); 1 means sample every clock.
- HOLD_TICKS, 8: sample ticks the level must stay high before the long-press strobe fires (≥1).
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pb_in  in  CH  raw (pre-synchronised) button levels, 1 = pressed.
- pb_level  out  CH  debounced level per channel.
- pb_press  out  CH  one-cycle strobe on debounced 0→1.
- pb_release  out  CH  one-cycle strobe on debounced 1→0.
- pb_long  out  CH  one-cycle strobe when a press has lasted HOLD_TICKS ticks.

## Operation
- **Tick divider.** One shared counter runs 0..SAMPLE_DIV-1. `tick`=1 in the cycle where the counter equals SAMPLE_DIV-1, then the counter wraps to 0. With SAMPLE_DIV=1, `tick` is constantly 1 and there is no counter.
- **Window.** Each channel has a DEPTH-bit shift register. On an edge with `tick`=1: `win <= {win[DEPTH-2:0], pb_in[i]}`. Otherwise it holds.
- **Level (registered, evaluated every clock):**
  - `win` all ones → pb_level goes to 1.
  - `win` all zeros → pb_level goes to 0.
  - Anything else → pb_level holds (hysteresis, no chatter on a mixed window).
- **Strobes (registered, same edge as the level update):**
  - pb_press=1 iff pb_level goes 0→1 at this edge.
  - pb_release=1 iff pb_level goes 1→0 at this edge.
  - Press and release never assert together on one channel.
- **Hold counter.** Per channel, width clog2(HOLD_TICKS+1), saturating at HOLD_TICKS.
  - On a tick edge with current (pre-edge) pb_level=1 and count<HOLD_TICKS: count+1.
  - The step to HOLD_TICKS asserts pb_long for exactly one cycle.
  - Once at HOLD_TICKS the counter stays there, and pb_long does not re-fire until after a release.
- **Counter clear.** At any edge where the next pb_level is 0, count clears to 0. The clear takes priority over an increment, and pb_long is suppressed at that edge.
- **Channel independence.** Channels are fully independent; only the tick divider is shared.

## Timing
- Reset (rst_n=0 at a clock edge) clears:
  - the divider;
  - all windows;
  - all hold counters;
  - pb_level, pb_press, pb_release, pb_long, which all read 0 in the cycle after that edge.
- Reset mid-operation discards partial windows. A held button must re-qualify over DEPTH full ticks.
- Press latency, pb_in stable high from before tick edge T1:
  - window full after the DEPTH-th tick edge;
  - pb_level and pb_press assert at the next clock edge;
  - total = (DEPTH-1)·SAMPLE_DIV + 2 edges after T1's preceding edge, i.e. DEPTH+1 edges when SAMPLE_DIV=1.
- Release latency is symmetric with press latency.
- pb_long asserts on the HOLD_TICKS-th tick edge at which pb_level was already 1 before the edge.
- Strobe width is always exactly one clock, independent of SAMPLE_DIV.
- pb_in is sampled only in tick cycles. Glitches between ticks are invisible.

## Test plan
All scenarios use CH=4, DEPTH=4, SAMPLE_DIV=1, HOLD_TICKS=8 unless stated. Edges E1, E2, … are the first, second, … rising edges after stimulus is applied.

- **Clean press, ch0.** pb_in[0]=1 before E1 and held.
  - Window 1111 after E4.
  - pb_level[0]=1 and pb_press[0]=1 after E5; pb_press[0]=0 after E6.
  - pb_long[0] high only after E13; no further pb_long while held.
- **Bounce rejected.** pb_in[1] pattern 1,0,1,1,0,1,1,0 over E1–E8, then 0.
  - pb_level[1] stays 0.
  - pb_press[1], pb_release[1], pb_long[1] never assert.
- **Release hysteresis.** ch0 debounced high; apply a single-cycle 0.
  - pb_level[0] stays 1.
  - Then 4 consecutive zeros (E1–E4): pb_level[0]=0 and pb_release[0]=1 after E5, with the hold count cleared.
  - Releasing at tick 5 of a hold produces no pb_long.
- **SAMPLE_DIV=3.** pb_in[2]=1 held.
  - Ticks occur every 3rd cycle.
  - pb_level[2] rises 1 edge after the 4th tick edge.
  - A 2-cycle low glitch placed between ticks is ignored.
- **Reset mid-press.** ch3 mid-hold (count=5); drive rst_n=0 for one edge.
  - All outputs are 0 the next cycle.
  - With pb_in[3] still 1 after rst_n=1, pb_press[3] re-fires after DEPTH+1 edges; pb_long[3] follows 8 ticks after that.
- **Simultaneous channels.** ch0 press and ch1 release apply the same cycle.
  - pb_press[0] and pb_release[1] strobe in the same cycle.
  - ch2/ch3 outputs remain 0.
